// File: rtl/fwd_pkg.sv
// fwd_pkg: opcodes, IR field positions, tag record and FSM states shared by the forwarding/hazard unit
package fwd_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;
  localparam int OP_MSB    = 31;
  localparam int IMM_BIT   = 26;
  localparam int RD_MSB    = 25;
  localparam int RS1_MSB   = 21;
  localparam int RS2_MSB   = 17;
  localparam int MAX_REG_W = 8;
  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] dest;
    logic                 is_load;
  } tag_t;
  typedef enum logic {ST_RUN, ST_STALL} fsm_t;
endpackage

// File: rtl/fwd_decode.sv
// fwd_decode: splits the OF instruction into destination tag and used source operands
//   in : of_ir
//   out: writes/dest/is_load (producer tag), uses1/uses2/uses_st with src1/src2/st_idx (consumers)
module fwd_decode import fwd_pkg::*; #(
  parameter int REG_W  = 4,
  parameter int RA_IDX = 15
) (
  input  logic [31:0]      of_ir,
  output logic             writes,
  output logic [REG_W-1:0] dest,
  output logic             is_load,
  output logic             uses1,
  output logic             uses2,
  output logic             uses_st,
  output logic [REG_W-1:0] src1,
  output logic [REG_W-1:0] src2,
  output logic [REG_W-1:0] st_idx
);
  logic [4:0]       op;
  logic             imm;
  logic [REG_W-1:0] rd;
  logic             unused_ok;
  assign op        = of_ir[OP_MSB -: 5];
  assign imm       = of_ir[IMM_BIT];
  assign rd        = of_ir[RD_MSB -: REG_W];
  assign unused_ok = ^of_ir[RS2_MSB-REG_W:0];
  assign writes  = !(op inside {OP_NOP, OP_CMP, OP_ST, OP_BEQ, OP_BGT, OP_B, OP_RET});
  assign dest    = op == OP_CALL ? REG_W'(RA_IDX) : rd;
  assign is_load = op == OP_LD;
  assign uses1   = !(op inside {OP_NOP, OP_MOV, OP_NOT, OP_B, OP_BEQ, OP_BGT, OP_CALL});
  assign src1    = op == OP_RET ? REG_W'(RA_IDX) : of_ir[RS1_MSB -: REG_W];
  // ALU opcodes occupy 00000..01100, so nop and branches fall outside this range
  assign uses2   = !imm && (op <= OP_ASR || op == OP_LD || op == OP_ST);
  assign src2    = of_ir[RS2_MSB -: REG_W];
  assign uses_st = op == OP_ST;
  assign st_idx  = rd;
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects and load-use stall control beside the OF stage
//   in : clk, rst_n (sync, active-low), of_ir, of_valid, advance, flush
//   out: stall_o, sel_src1/sel_src2/sel_st (0 = regfile, k = stage k), stall_cnt, fwd_cnt
//   FWD_STATS_EN: when defined, stall_cnt/fwd_cnt are saturating event counters; otherwise tied to 0
module fwd_hazard_unit import fwd_pkg::*; #(
  parameter int NUM_STAGES = 3,
  parameter int REG_W      = 4,
  parameter int RA_IDX     = 15,
  parameter int LOAD_STALL = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      of_ir,
  input  logic             of_valid,
  input  logic             advance,
  input  logic             flush,
  output logic             stall_o,
  output logic [SEL_W-1:0] sel_src1,
  output logic [SEL_W-1:0] sel_src2,
  output logic [SEL_W-1:0] sel_st,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      fwd_cnt
);
  localparam int CNT_W = LOAD_STALL > 1 ? $clog2(LOAD_STALL) : 1;
  logic             writes, is_load, uses1, uses2, uses_st, hazard;
  logic [REG_W-1:0] dest, src1, src2, st_idx;
  logic [SEL_W-1:0] s1, s2, ss;
  tag_t             of_tag;
  tag_t             ent_q [1:NUM_STAGES];
  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fwd_decode #(.REG_W(REG_W), .RA_IDX(RA_IDX)) u_dec (
    .of_ir(of_ir), .writes(writes), .dest(dest), .is_load(is_load),
    .uses1(uses1), .uses2(uses2), .uses_st(uses_st),
    .src1(src1), .src2(src2), .st_idx(st_idx)
  );
  function automatic logic hit(tag_t t, logic [REG_W-1:0] idx);
    return t.valid && t.dest == MAX_REG_W'(idx);
  endfunction
  assign of_tag = '{valid: of_valid && !stall_o && !flush && writes,
                    dest: MAX_REG_W'(dest), is_load: is_load};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= NUM_STAGES; k++) ent_q[k] <= '0;
    end else begin
      if (advance) begin
        for (int k = NUM_STAGES; k > 1; k--) ent_q[k] <= ent_q[k-1];
        ent_q[1] <= of_tag;
      end
      if (flush) ent_q[1] <= '0;
    end
  end
  // Descending scan so the youngest matching producer overrides older ones
  always_comb begin
    s1 = '0;
    s2 = '0;
    ss = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (uses1 && hit(ent_q[k], src1)) s1 = SEL_W'(k);
      if (uses2 && hit(ent_q[k], src2)) s2 = SEL_W'(k);
      if (uses_st && hit(ent_q[k], st_idx)) ss = SEL_W'(k);
    end
  end
  assign hazard   = ent_q[1].is_load && ((uses1 && hit(ent_q[1], src1)) ||
                    (uses2 && hit(ent_q[1], src2)) || (uses_st && hit(ent_q[1], st_idx)));
  assign stall_o  = state_q == ST_STALL || hazard;
  assign sel_src1 = stall_o ? '0 : s1;
  assign sel_src2 = stall_o ? '0 : s2;
  assign sel_st   = stall_o ? '0 : ss;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (hazard && advance && LOAD_STALL > 1) begin
        state_d = ST_STALL;
        cnt_d   = CNT_W'(LOAD_STALL - 1);
      end
    end else if (advance) begin
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == CNT_W'(1) ? ST_RUN : ST_STALL;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef FWD_STATS_EN
  logic [15:0] stall_cnt_q, fwd_cnt_q;
  logic        any_fwd;
  assign any_fwd = |{sel_src1, sel_src2, sel_st};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_o && advance && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (any_fwd && advance && fwd_cnt_q != 16'hFFFF) fwd_cnt_q <= fwd_cnt_q + 16'd1;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scoreboard bench for fwd_hazard_unit (LOAD_STALL 1 and 2 instances)
module tb_fwd_hazard_unit;
  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, CMP = 5'b00101, MOV = 5'b01001;
  localparam logic [4:0] LD = 5'b01110, ST = 5'b01111, CALL = 5'b10011, RET = 5'b10100;
  typedef struct {
    bit         which;
    logic       stall;
    logic [1:0] s1, s2, st;
  } exp_t;
  logic        clk = 0, rst_n = 0, vld = 1, adv = 0, fl = 0;
  logic [31:0] ir = '0;
  logic        a_stall, b_stall;
  logic [1:0]  a_s1, a_s2, a_st, b_s1, b_s2, b_st;
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
  int          n_chk = 0, n_fail = 0;
  exp_t        exp_q[$];
  string       nm_q[$];
  fwd_hazard_unit u_a (
    .clk(clk), .rst_n(rst_n), .of_ir(ir), .of_valid(vld), .advance(adv), .flush(fl),
    .stall_o(a_stall), .sel_src1(a_s1), .sel_src2(a_s2), .sel_st(a_st),
    .stall_cnt(a_sc), .fwd_cnt(a_fc)
  );
  fwd_hazard_unit #(.LOAD_STALL(2)) u_b (
    .clk(clk), .rst_n(rst_n), .of_ir(ir), .of_valid(vld), .advance(adv), .flush(fl),
    .stall_o(b_stall), .sel_src1(b_s1), .sel_src2(b_s2), .sel_st(b_st),
    .stall_cnt(b_sc), .fwd_cnt(b_fc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ri(logic [4:0] op, logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2);
    return {op, 1'b0, rd, rs1, rs2, 14'd0};
  endfunction
  function automatic logic [31:0] ii(logic [4:0] op, logic [3:0] rd, logic [3:0] rs1, logic [17:0] imm);
    return {op, 1'b1, rd, rs1, imm};
  endfunction
  task automatic cmp(input string nm, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, expv);
    end
  endtask
  task automatic step(input string nm, input logic [31:0] i, input bit a, input bit f, input bit which,
                      input logic stl, input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] es);
    exp_t e, g;
    string n;
    ir = i;
    adv = a;
    fl = f;
    e = '{which: which, stall: stl, s1: e1, s2: e2, st: es};
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    g = exp_q.pop_front();
    n = nm_q.pop_front();
    cmp({n, ".stall"}, 16'(g.which ? b_stall : a_stall), 16'(g.stall));
    cmp({n, ".src1"}, 16'(g.which ? b_s1 : a_s1), 16'(g.s1));
    cmp({n, ".src2"}, 16'(g.which ? b_s2 : a_s2), 16'(g.s2));
    cmp({n, ".st"}, 16'(g.which ? b_st : a_st), 16'(g.st));
    @(posedge clk);
    #1;
  endtask
  task automatic cnts(input string nm, input bit which, input logic [15:0] sc, input logic [15:0] fc);
`ifdef FWD_STATS_EN
    cmp({nm, ".stall_cnt"}, which ? b_sc : a_sc, sc);
    cmp({nm, ".fwd_cnt"}, which ? b_fc : a_fc, fc);
`else
    cmp({nm, ".stall_cnt"}, which ? b_sc : a_sc, 16'd0 & sc);
    cmp({nm, ".fwd_cnt"}, which ? b_fc : a_fc, 16'd0 & fc);
`endif
  endtask
  initial begin
    @(posedge clk);
    #1;
    step("reset", ri(ADD, 4, 1, 1), 1, 0, 0, 0, 0, 0, 0);
    cnts("reset", 0, 0, 0);
    rst_n = 1;
    vld = 0;
    step("invalid", ri(ADD, 1, 2, 3), 1, 0, 0, 0, 0, 0, 0);
    vld = 1;
    step("after_bubble", ri(ADD, 4, 1, 5), 1, 0, 0, 0, 0, 0, 0);
    step("add_prod", ri(ADD, 1, 2, 3), 1, 0, 0, 0, 0, 0, 0);
    step("ex_fwd", ri(ADD, 4, 1, 5), 1, 0, 0, 0, 1, 0, 0);
    step("ld", ii(LD, 1, 2, 0), 1, 0, 0, 0, 0, 0, 0);
    step("ld_use_stall", ri(ADD, 2, 1, 3), 1, 0, 0, 1, 0, 0, 0);
    step("ld_use_ma", ri(ADD, 2, 1, 3), 1, 0, 0, 0, 2, 0, 0);
    cnts("ld_use", 0, 1, 2);
    step("older_r1", ri(ADD, 1, 5, 6), 1, 0, 0, 0, 0, 0, 0);
    step("younger_r1", ri(SUB, 1, 7, 8), 1, 0, 0, 0, 0, 0, 0);
    step("youngest", ri(ADD, 9, 1, 1), 1, 0, 0, 0, 1, 1, 0);
    step("call", {CALL, 27'd8}, 1, 0, 0, 0, 0, 0, 0);
    step("ret", {RET, 27'd0}, 1, 0, 0, 0, 1, 0, 0);
    step("mov", ii(MOV, 1, 0, 5), 1, 0, 0, 0, 0, 0, 0);
    step("st_data", ii(ST, 1, 2, 4), 1, 0, 0, 0, 0, 0, 1);
    step("hold", ri(ADD, 3, 1, 0), 0, 0, 0, 0, 2, 0, 0);
    step("cmp_src2", ri(CMP, 0, 0, 1), 1, 0, 0, 0, 0, 2, 0);
    cnts("run_a", 0, 1, 6);
    rst_n = 0;
    step("reset_b", ri(ADD, 0, 0, 0), 0, 0, 1, 0, 0, 0, 0);
    rst_n = 1;
    step("b_ld", ii(LD, 3, 2, 0), 1, 0, 1, 0, 0, 0, 0);
    step("b_stall1", ri(ADD, 4, 3, 3), 1, 0, 1, 1, 0, 0, 0);
    step("b_hold", ri(ADD, 4, 3, 3), 0, 0, 1, 1, 0, 0, 0);
    step("b_stall2", ri(ADD, 4, 3, 3), 1, 0, 1, 1, 0, 0, 0);
    step("b_release", ri(ADD, 4, 3, 3), 1, 0, 1, 0, 3, 3, 0);
    cnts("b_ls2", 1, 2, 1);
    step("b_ld2", ii(LD, 3, 2, 0), 1, 0, 1, 0, 0, 0, 0);
    step("b_stall3", ri(ADD, 4, 3, 3), 1, 0, 1, 1, 0, 0, 0);
    step("b_flush", ri(ADD, 4, 3, 3), 1, 1, 1, 1, 0, 0, 0);
    step("b_post_flush", ri(ADD, 5, 6, 7), 0, 0, 1, 0, 0, 0, 0);
    cnts("b_flush", 1, 4, 1);
    step("b_ld3", ii(LD, 3, 2, 0), 1, 0, 1, 0, 0, 0, 0);
    step("b_stall4", ri(ADD, 4, 3, 3), 1, 0, 1, 1, 0, 0, 0);
    rst_n = 0;
    step("b_rst_in_stall", ri(ADD, 4, 3, 3), 1, 0, 1, 1, 0, 0, 0);
    rst_n = 1;
    step("b_after_rst", ri(ADD, 4, 3, 3), 0, 0, 1, 0, 0, 0, 0);
    cnts("b_after_rst", 1, 0, 0);
    cnts("a_after_rst", 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
